alu_mul_sequencer: RTL and testbench
====================================

Name: alu_mul_sequencer

Overview:
- Multi-cycle 16x16 multiplier that computes the low 16 bits of OPA*OPB by shift-and-add.
- It has no arithmetic of its own. Every add, shift and bit-test runs on the shared 16-bit ALU (ops ADD/SUB/SLL/SRL/OR/AND, plus a zero flag), one ALU operation per cycle.
- It sits beside the multi-cycle CPU datapath. It gets the ALU through a request/grant handshake and gives the ALU back between multiplies.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU width.
- OP_ADD, 3'd0, ALU opcode for A+B.
- OP_SLL, 3'd2, ALU opcode for A<<B.
- OP_SRL, 3'd3, ALU opcode for logical A>>B.
- OP_AND, 3'd5, ALU opcode for A&B.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  start pulse; sampled only in IDLE.
- OPA  in  WIDTH  multiplicand; latched when START is accepted.
- OPB  in  WIDTH  multiplier; latched when START is accepted.
- BUSY  out  1  high from the cycle after START is accepted through the DONE cycle.
- DONE  out  1  one-cycle pulse; RESULT is valid.
- RESULT  out  WIDTH  product low bits; held until the next accepted START.
- ALU_REQ  out  1  requests the shared ALU.
- ALU_GNT  in  1  ALU granted this cycle.
- ALU_A  out  WIDTH  ALU operand A.
- ALU_B  out  WIDTH  ALU operand B.
- ALU_OP  out  3  ALU opcode.
- ALU_OUT  in  WIDTH  ALU result (combinational, same cycle).
- ALU_ZERO  in  1  ALU zero flag (ALU_OUT == 0).

Behaviour:
- Registers: MCAND, MULT, ACC (all WIDTH wide), plus the state register.
- Reset (RESET=1 at an edge, in any state including mid-operation):
  - state=IDLE; MCAND=MULT=ACC=0; RESULT=0.
  - BUSY=0, DONE=0, ALU_REQ=0. ALU_A=0, ALU_B=0, ALU_OP=OP_ADD.
  - The operation in progress is discarded.
- States: IDLE, CHECK, ADD, SHL, SHR, FIN.
- IDLE:
  - ALU_REQ=0; ALU outputs as in reset.
  - START=1 -> MCAND<=OPA, MULT<=OPB, ACC<=0, go to CHECK.
- CHECK: ALU_A=MULT, ALU_B=1, ALU_OP=OP_AND.
  - ALU_ZERO=0 -> ADD.
  - ALU_ZERO=1 -> SHL.
- ADD: ALU_A=ACC, ALU_B=MCAND, ALU_OP=OP_ADD. ACC<=ALU_OUT; go to SHL.
- SHL: ALU_A=MCAND, ALU_B=1, ALU_OP=OP_SLL. MCAND<=ALU_OUT; go to SHR.
- SHR: ALU_A=MULT, ALU_B=1, ALU_OP=OP_SRL. MULT<=ALU_OUT.
  - ALU_ZERO=1 -> FIN (early termination).
  - ALU_ZERO=0 -> CHECK.
- FIN:
  - DONE=1, BUSY=1, ALU_REQ=0; RESULT<=ACC at this edge; go to IDLE.
  - RESULT is also visible during FIN, driven combinationally from ACC.
- ALU_REQ=1 in CHECK, ADD, SHL and SHR.
- Stall: if ALU_GNT=0 in any of those states, nothing advances.
  - State, MCAND, MULT and ACC hold.
  - ALU_A/B/OP stay driven and the ALU result is ignored.
  - A stall adds exactly one cycle per low-GNT cycle.
- Arithmetic:
  - Two's-complement wrap, low WIDTH bits only, no overflow flag.
  - Signed and unsigned operands give identical low bits.
  - SRL is logical, so MULT reaches 0 after at most 16 SHR steps.
- Latency with GNT held high, counting from the START edge:
  - 3 cycles per multiplier bit, plus 1 extra for each set bit.
  - Iterations = index of the highest set bit of OPB + 1, minimum 1.
  - FIN follows, so DONE rises in cycle latency+1.
- START is ignored when not in IDLE, including during FIN.
- START held high is re-accepted on the first IDLE cycle after FIN.

Test Plan:
- Reset, GNT=1, OPA=3, OPB=5, START one cycle -> CHECK/ADD/SHL/SHR x3 iterations (11 cycles), DONE in cycle 12, RESULT=0x000F, BUSY low at cycle 13.
- OPA=0xFFFD (-3), OPB=5 -> RESULT=0xFFF1 in cycle 12. Then OPA=0x1234, OPB=0 -> CHECK,SHL,SHR; DONE in cycle 4; RESULT=0x0000.
- OPA=1, OPB=0xFFFF -> 64 ALU cycles, DONE in cycle 65, RESULT=0xFFFF. OPA=0x0100, OPB=0x0100 -> RESULT=0x0000 (wrap).
- OPA=3, OPB=5, ALU_GNT low for 4 cycles during the first ADD -> ACC and state hold, ALU_REQ stays 1, DONE in cycle 16, RESULT=0x000F.
- START pulsed while BUSY, and during FIN, with OPA=7 -> ignored; RESULT stays from the first operation; no second DONE.
- RESET asserted in the cycle after the second SHL -> next cycle state IDLE, BUSY=DONE=ALU_REQ=0, RESULT=0. A fresh START(2,3) -> RESULT=0x0006.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: 16x16 shift-and-add multiplier, low WIDTH bits of the product.
// All add, shift and bit-test work is done on the shared ALU. The ALU is
// requested with alu_req/alu_gnt and released between multiplies.
// ALU operand/opcode outputs are registered and are loaded one edge ahead.
// When a state is entered, its ALU command is already on the bus.
module alu_mul_sequencer #(
    parameter int         WIDTH  = 16,
    parameter logic [2:0] OP_ADD = 3'd0,
    parameter logic [2:0] OP_SLL = 3'd2,
    parameter logic [2:0] OP_SRL = 3'd3,
    parameter logic [2:0] OP_AND = 3'd5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ADD,
        S_SHL,
        S_SHR,
        S_FIN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mult;
    logic [WIDTH-1:0] acc;

    // Sequencer FSM: datapath registers, handshake and ALU command, all registered.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below sees the values from before this clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            mcand   <= '0;
            mult    <= '0;
            acc     <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            alu_req <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= OP_ADD;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand   <= opa;
                        mult    <= opb;
                        acc     <= '0;
                        busy    <= 1'b1;
                        alu_req <= 1'b1;
                        alu_a   <= opb;
                        alu_b   <= ONE;
                        alu_op  <= OP_AND;
                        state   <= S_CHECK;
                    end
                end

                // NOTE: without a grant, nothing is assigned. In a clocked
                // block this means "hold" (a flop enable), not a latch.
                S_CHECK: begin
                    if (alu_gnt) begin
                        if (!alu_zero) begin
                            alu_a  <= acc;
                            alu_b  <= mcand;
                            alu_op <= OP_ADD;
                            state  <= S_ADD;
                        end else begin
                            alu_a  <= mcand;
                            alu_b  <= ONE;
                            alu_op <= OP_SLL;
                            state  <= S_SHL;
                        end
                    end
                end

                S_ADD: begin
                    if (alu_gnt) begin
                        acc    <= alu_out;
                        alu_a  <= mcand;
                        alu_b  <= ONE;
                        alu_op <= OP_SLL;
                        state  <= S_SHL;
                    end
                end

                S_SHL: begin
                    if (alu_gnt) begin
                        mcand  <= alu_out;
                        alu_a  <= mult;
                        alu_b  <= ONE;
                        alu_op <= OP_SRL;
                        state  <= S_SHR;
                    end
                end

                S_SHR: begin
                    if (alu_gnt) begin
                        mult <= alu_out;
                        if (alu_zero) begin
                            // No multiplier bits left. Release the ALU and present the product.
                            result  <= acc;
                            done    <= 1'b1;
                            alu_req <= 1'b0;
                            alu_a   <= '0;
                            alu_b   <= '0;
                            alu_op  <= OP_ADD;
                            state   <= S_FIN;
                        end else begin
                            alu_a  <= alu_out;
                            alu_b  <= ONE;
                            alu_op <= OP_AND;
                            state  <= S_CHECK;
                        end
                    end
                end

                S_FIN: begin
                    // START is deliberately not sampled here.
                    result <= acc;
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed bench with a behavioural shared ALU and a result scoreboard.
module tb_alu_mul_sequencer;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_SLL = 3'd2;
    localparam logic [2:0] OP_SRL = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] opa = '0;
    logic [15:0] opb = '0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        alu_req;
    logic        alu_gnt = 1'b1;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_op;
    logic [15:0] alu_out;
    logic        alu_zero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    logic [15:0] sb[$];
    logic [15:0] mon_exp;

    alu_mul_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .opa      (opa),
        .opb      (opb),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .alu_req  (alu_req),
        .alu_gnt  (alu_gnt),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_out  (alu_out),
        .alu_zero (alu_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shared ALU model.
    always_comb begin
        alu_out = '0;
        case (alu_op)
            OP_ADD: alu_out = alu_a + alu_b;
            OP_SUB: alu_out = alu_a - alu_b;
            OP_SLL: alu_out = alu_a << alu_b;
            OP_SRL: alu_out = alu_a >> alu_b;
            OP_OR:  alu_out = alu_a | alu_b;
            OP_AND: alu_out = alu_a & alu_b;
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == 16'h0000);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // DONE cycle counted from the START edge: 3 per iterated bit, +1 per set bit, +1 for FIN.
    function automatic int exp_done_cycle(input logic [15:0] b);
        int iters = 1;
        int ones = 0;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) begin
                iters = i + 1;
                ones++;
            end
        end
        return 3 * iters + ones + 1;
    endfunction

    // Scoreboard consumer: every DONE must match one outstanding expected product.
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            check("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                check("sb_result", 32'(result), 32'(mon_exp));
            end
        end
    end

    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = {16'h0, a} * {16'h0, b};
        sb.push_back(p[15:0]);
        opa = a;
        opb = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc, input logic [15:0] exp_res);
        int lat = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = cyc - start_cyc + 1;
                break;
            end
        end
        check({tag, "_done_cycle"}, 32'(lat), 32'(exp_cyc));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_after"}, 32'(done), 32'd0);
        check({tag, "_result_held"}, 32'(result), 32'(exp_res));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req", 32'(alu_req), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'(OP_ADD));
        reset = 1'b0;

        // 3 * 5
        start_op(16'd3, 16'd5);
        check("op1_req", 32'(alu_req), 32'd1);
        check("op1_check_op", 32'(alu_op), 32'(OP_AND));
        wait_done("op1", exp_done_cycle(16'd5), 16'h000F);

        // -3 * 5, then x * 0
        start_op(16'hFFFD, 16'd5);
        wait_done("op2", 12, 16'hFFF1);
        start_op(16'h1234, 16'h0000);
        wait_done("op3", 4, 16'h0000);

        // Full multiplier, then wrap
        start_op(16'h0001, 16'hFFFF);
        wait_done("op4", 65, 16'hFFFF);
        start_op(16'h0100, 16'h0100);
        wait_done("op5", exp_done_cycle(16'h0100), 16'h0000);

        // Grant withheld for 4 cycles during the first ADD
        start_op(16'd3, 16'd5);
        @(posedge clk);
        #1;
        alu_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_req", 32'(alu_req), 32'd1);
            check("stall_op", 32'(alu_op), 32'(OP_ADD));
            check("stall_acc", 32'(alu_a), 32'd0);
            check("stall_mcand", 32'(alu_b), 32'd3);
            @(posedge clk);
            #1;
        end
        alu_gnt = 1'b1;
        wait_done("stall", 16, 16'h000F);

        // START pulses while busy and during FIN are ignored
        start_op(16'd3, 16'd5);
        repeat (3) @(posedge clk);
        #1;
        opa = 16'd7;
        opb = 16'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("ign_fin_done", 32'(done), 32'd1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign_busy", 32'(busy), 32'd0);
        check("ign_done", 32'(done), 32'd0);
        check("ign_result", 32'(result), 32'h000F);
        repeat (3) @(posedge clk);
        #1;
        check("ign_still_idle", 32'(busy), 32'd0);
        check("ign_no_done", 32'(done), 32'd0);
        check("ign_result_held", 32'(result), 32'h000F);

        // Reset in the cycle after the second SHL
        start_op(16'd3, 16'd5);
        repeat (6) @(posedge clk);
        #1;
        check("rst2_in_shr", 32'(alu_op), 32'(OP_SRL));
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_done", 32'(done), 32'd0);
        check("rst2_req", 32'(alu_req), 32'd0);
        check("rst2_result", 32'(result), 32'd0);
        check("rst2_alu_op", 32'(alu_op), 32'(OP_ADD));
        check("rst2_alu_a", 32'(alu_a), 32'd0);
        reset = 1'b0;

        // Fresh operation after reset
        start_op(16'd2, 16'd3);
        wait_done("post_rst", exp_done_cycle(16'd3), 16'h0006);

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
